// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider.
// The core drives writes and enables; the divider returns clocks and strobes.
interface clk_div_prog_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic                    wr_en;
    logic [CH_W-1:0]         wr_ch;
    logic [CNT_W-1:0]        wr_div;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       sclk;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       rise;
    logic [NUM_CH*CNT_W-1:0] div_q;

    modport master (
        output wr_en, wr_ch, wr_div, ch_en,
        input  sclk, tick, rise, div_q
    );

    modport slave (
        input  wr_en, wr_ch, wr_div, ch_en,
        output sclk, tick, rise, div_q
    );
endinterface

// File: rtl/clk_div_prog.sv
// Run-time programmable multi-channel clock divider.
// Each channel toggles sclk every div+1 enabled cycles and pulses tick/rise.
module clk_div_prog #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 200000,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    clk_div_prog_if.slave   bus
);

    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] div_r;
        logic [CNT_W-1:0] cnt_r;
        logic             sclk_r;
        logic             tick_r;
        logic             rise_r;
        logic             wr_hit;
        logic             term;

        // Out-of-range channel numbers never match, so such writes are dropped.
        assign wr_hit = bus.wr_en && (bus.wr_ch == CH_W'(i));
        assign term   = (cnt_r == div_r);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                div_r  <= DEF;
                cnt_r  <= '0;
                sclk_r <= 1'b0;
                tick_r <= 1'b0;
                rise_r <= 1'b0;
            end else if (wr_hit) begin
                div_r  <= bus.wr_div;
                cnt_r  <= '0;
                sclk_r <= 1'b0;
                tick_r <= 1'b0;
                rise_r <= 1'b0;
            end else if (!bus.ch_en[i]) begin
                cnt_r  <= '0;
                sclk_r <= 1'b0;
                tick_r <= 1'b0;
                rise_r <= 1'b0;
            end else if (term) begin
                cnt_r  <= '0;
                sclk_r <= ~sclk_r;
                tick_r <= 1'b1;
                rise_r <= ~sclk_r;
            end else begin
                cnt_r  <= cnt_r + 1'b1;
                tick_r <= 1'b0;
                rise_r <= 1'b0;
            end
        end

        assign bus.sclk[i]                 = sclk_r;
        assign bus.tick[i]                 = tick_r;
        assign bus.rise[i]                 = rise_r;
        assign bus.div_q[i*CNT_W +: CNT_W] = div_r;
    end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Parametrised, run-time programmable multi-channel clock divider. It generates NUM_CH independent square-wave slow clocks and matching single-cycle enable pulses from one system clock. Each channel's half-period can be reprogrammed by the core, or held at a build-time default. It replaces fixed-count dividers for display multiplexing, debounce sampling and peripheral strobes. Outputs are registered logic signals in the `clk` domain; downstream logic should use `tick`/`rise` as clock enables rather than clocking from `sclk`.

## Interface

Parameters:
- NUM_CH, 4: number of divider channels (1..16).
- CNT_W, 32: width of divisor and counter registers.
- DEFAULT_DIV, 200000: reset value of every channel's divisor register. Must fit in CNT_W bits.
- CH_W, $clog2(NUM_CH) (minimum 1): width of the channel select.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- wr_en  in  1  divisor write strobe, one cycle.
- wr_ch  in  CH_W  channel addressed by the write.
- wr_div  in  CNT_W  new half-period divisor value.
- ch_en  in  NUM_CH  per-channel run enable.
- sclk  out  NUM_CH  per-channel divided clock.
- tick  out  NUM_CH  one-cycle pulse on every sclk toggle.
- rise  out  NUM_CH  one-cycle pulse only on 0->1 sclk toggles.
- div_q  out  NUM_CH*CNT_W  current divisor of each channel; channel i occupies bits [i*CNT_W +: CNT_W].

## Operation

- Each channel i has three registers: `div[i]` (CNT_W bits), `cnt[i]` (CNT_W bits) and `sclk[i]`.
- Reset (rst_n=0 at a clk edge):
  - `div` = DEFAULT_DIV
  - `cnt` = 0
  - sclk, tick and rise = 0 on all channels
  - reset overrides writes and enables.
- Run (ch_en[i]=1, no write to i):
  - If cnt[i]==div[i]: sclk[i] toggles, cnt[i]←0, tick[i]←1. rise[i]←1 only if the new sclk is 1.
  - Otherwise: cnt[i]←cnt[i]+1, and tick and rise ←0.
- Half-period is div+1 cycles; full period is 2*(div+1) cycles. div=0 gives clk/2 with tick high every cycle.
- Counter arithmetic is unsigned. cnt never exceeds div in normal operation. If cnt>div after a write race, the counter wraps through 2^CNT_W. This case cannot occur because writes clear cnt.
- Disable (ch_en[i]=0):
  - cnt[i]←0 and sclk[i]←0; tick and rise ←0.
  - div[i] is retained.
  - Re-enabling starts from phase 0.
- Write (wr_en=1, wr_ch=i, i<NUM_CH):
  - div[i]←wr_div, cnt[i]←0, sclk[i]←0; tick and rise ←0. This is a phase restart.
  - The write is accepted regardless of ch_en[i].
  - Write beats a coincident terminal count: no toggle and no pulse on that edge.
- A write with wr_ch≥NUM_CH is ignored; no state changes.
- Channels are fully independent. A write to one channel never disturbs another.
- div_q reflects the div registers directly (registered, no extra latency).

## Timing

- All outputs are registered. There is no combinational path from input to output.
- Enabled channel, first edge with ch_en=1 after reset or write: cnt=0. The first sclk rise occurs at the (div+1)-th enabled edge after the restart.
- tick and rise go high in the same cycle as the new sclk value and last exactly one cycle.
- Write latency: the new divisor is visible on div_q one cycle after the wr_en edge. The next toggle then follows div+1 enabled edges later.
- Enable deassert takes effect on the same edge. sclk is low the cycle after, even mid-high-phase.
- Reset applied mid-period takes effect on that edge. Custom divisors are lost and return to DEFAULT_DIV.

## Test plan

- **Reset and default:** NUM_CH=2, DEFAULT_DIV=3, assert rst_n=0 for 2 cycles, then release with ch_en=2'b11.
  - Required: sclk=0, tick=0 and div_q={3,3} during reset.
  - Required: first sclk rise on the 4th edge after release, period 8 cycles.
  - Required: tick every 4 cycles, rise every 8 cycles.
- **Divisor write with phase restart:** channel 0 running with div=3. Write wr_div=1 to channel 0 while sclk[0]=1.
  - Required: sclk[0]=0 next cycle, div_q[0]=1.
  - Required: period then 4 cycles.
  - Required: channel 1 waveform unchanged.
- **div=0:** write 0 to channel 1.
  - Required: sclk[1] toggles every cycle, tick[1] continuously 1, rise[1] alternates 1/0.
- **Write/terminal-count collision:** write wr_div=5 on the exact edge where cnt==div.
  - Required: no toggle and no tick on that edge; next tick 6 cycles later.
- **Enable gating and out-of-range write:** NUM_CH=3. Drop ch_en[2] mid-high-phase, then write wr_ch=3.
  - Required: sclk[2]=0 and tick[2]=0 while disabled.
  - Required: the write to channel 3 leaves all div_q values unchanged.
  - Required: after re-enable, the first rise arrives div+1 edges later.
- **Reset mid-operation:** after custom writes, assert rst_n=0 for one cycle.
  - Required: all div_q=DEFAULT_DIV, all counters restart, and all outputs are 0 in the cycle after reset.
